// File: rtl/maze_pkg.sv
// Shared map geometry, requester tags and the response-pipeline entry used by
// the map ROM arbiter.
package maze_pkg;

    localparam int MAP_W      = 30;
    localparam int MAP_DEPTH  = 21;
    localparam int MAP_ADDR_W = 5;
    localparam int MAP_COL_W  = 5;

    typedef enum logic {
        OWN_VGA  = 1'b0,
        OWN_GAME = 1'b1
    } owner_e;

    typedef struct packed {
        logic                 valid;
        owner_e               owner;
        logic                 oor;
        logic [MAP_COL_W-1:0] col;
    } pipe_entry_t;

endpackage

// File: rtl/map_arb_pipe.sv
// Two-stage tagged response pipeline: stage 0 lines up with the ROM address
// register, stage 1 with the ROM's registered data output.
module map_arb_pipe
    import maze_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  pipe_entry_t inEntry,
    output pipe_entry_t outEntry
);

    pipe_entry_t stage [2];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stage[0] <= '0;
            stage[1] <= '0;
        end else begin
            stage[0] <= inEntry;
            stage[1] <= stage[0];
        end
    end

    assign outEntry = stage[1];

endmodule

// File: rtl/map_rom_arbiter.sv
// Shares one synchronous map ROM between the VGA row fetcher and the game's
// wall query. Optional starvation guard: MAP_ARB_STARVE_GUARD_EN.
module map_rom_arbiter
    import maze_pkg::*;
#(
    parameter int DATA_W     = MAP_W,
    parameter int DEPTH      = MAP_DEPTH,
    parameter int ADDR_W     = MAP_ADDR_W,
    parameter int COL_W      = MAP_COL_W,
    parameter int STARVE_MAX = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              game_req,
    input  logic [ADDR_W-1:0] game_row,
    input  logic [COL_W-1:0]  game_col,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic              game_wall,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    logic forceGame;

`ifdef MAP_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starveCnt;

    assign forceGame = (int'(starveCnt) >= STARVE_MAX);

    // Saturates at STARVE_MAX; the forced grant that follows clears it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            starveCnt <= '0;
        else if (!game_req || game_gnt)
            starveCnt <= '0;
        else if (!forceGame)
            starveCnt <= starveCnt + 1'b1;
    end
`else
    assign forceGame = 1'b0;
`endif

    // Grants are held low during reset so nothing is issued across it.
    assign vga_gnt  = !Reset && vga_req && !(forceGame && game_req);
    assign game_gnt = !Reset && game_req && (!vga_req || forceGame);

    logic              anyGnt;
    logic [ADDR_W-1:0] selRow;
    logic [COL_W-1:0]  selCol;
    logic              issueOor;

    assign anyGnt   = vga_gnt || game_gnt;
    assign selRow   = vga_gnt ? vga_addr : game_row;
    assign selCol   = vga_gnt ? '0 : game_col;
    assign issueOor = (int'(selRow) >= DEPTH);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            rom_addr <= '0;
        else if (anyGnt && !issueOor)
            rom_addr <= selRow;
    end

    pipe_entry_t inEntry;
    pipe_entry_t outEntry;

    always_comb begin
        inEntry       = '0;
        inEntry.valid = anyGnt;
        inEntry.owner = vga_gnt ? OWN_VGA : OWN_GAME;
        inEntry.oor   = issueOor;
        inEntry.col   = MAP_COL_W'(selCol);
    end

    map_arb_pipe u_pipe (
        .Clk      (Clk),
        .Reset    (Reset),
        .inEntry  (inEntry),
        .outEntry (outEntry)
    );

    logic              colOor;
    logic [DATA_W-1:0] shifted;

    // Column 0 is the row MSB: shift the queried cell up into the top bit.
    assign colOor  = (int'(outEntry.col) >= DATA_W);
    assign shifted = rom_data << outEntry.col;

    assign vga_rvalid  = outEntry.valid && (outEntry.owner == OWN_VGA);
    assign game_rvalid = outEntry.valid && (outEntry.owner == OWN_GAME);
    assign vga_rdata   = outEntry.oor ? '1 : rom_data;
    assign game_wall   = game_rvalid && (outEntry.oor || colOor || shifted[DATA_W-1]);

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed + random bench for map_rom_arbiter with a scoreboard of expected
// responses and a local registered-read ROM model holding the maze rows.
module tb_map_rom_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        vga_req;
    logic [4:0]  vga_addr;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [29:0] vga_rdata;
    logic        game_req;
    logic [4:0]  game_row;
    logic [4:0]  game_col;
    logic        game_gnt;
    logic        game_rvalid;
    logic        game_wall;
    logic [4:0]  rom_addr;
    logic [29:0] rom_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    map_rom_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .game_req(game_req), .game_row(game_row), .game_col(game_col),
        .game_gnt(game_gnt), .game_rvalid(game_rvalid), .game_wall(game_wall),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    // ROM model: maze-like rows, border cells always walls.
    logic [29:0] mem [21];
    initial begin
        for (int r = 0; r < 21; r++) begin
            if (r == 0 || r == 20) mem[r] = '1;
            else mem[r] = 30'((r * 32'h9E3779B1) ^ 32'h0A5C3F17) | 30'h2000_0001;
        end
    end
    always @(posedge Clk) rom_data <= mem[rom_addr];

    function automatic logic [29:0] expRow(input int row);
        return (row < 21) ? mem[row] : '1;
    endfunction

    function automatic logic expWall(input int row, input int col);
        logic [29:0] r;
        if (row >= 21 || col >= 30) return 1'b1;
        r = mem[row];
        return r[29 - col];
    endfunction

    typedef struct {
        bit          isGame;
        logic [29:0] data;
        logic        wall;
        int          cyc;
    } exp_t;
    exp_t q[$];

    // Monitor: check responses first, then log this cycle's grant.
    always @(negedge Clk) begin
        exp_t e;
        if (Reset) begin
            q.delete();
            chk("rst_vga_gnt", vga_gnt, 1'b0);
            chk("rst_game_gnt", game_gnt, 1'b0);
            chk("rst_vga_rvalid", vga_rvalid, 1'b0);
            chk("rst_game_rvalid", game_rvalid, 1'b0);
            chk("rst_game_wall", game_wall, 1'b0);
            chk("rst_rom_addr", rom_addr, 5'd0);
        end else begin
            chk("gnt_onehot", vga_gnt && game_gnt, 1'b0);
            chk("rvalid_onehot", vga_rvalid && game_rvalid, 1'b0);
            if (vga_rvalid || game_rvalid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rvalid", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("resp_owner", game_rvalid, e.isGame);
                    chk("resp_latency", cyc, e.cyc + 2);
                    if (e.isGame) chk("game_wall", game_wall, e.wall);
                    else chk("vga_rdata", vga_rdata, e.data);
                end
            end else begin
                chk("idle_game_wall", game_wall, 1'b0);
                if (q.size() > 0 && cyc >= q[0].cyc + 2) begin
                    chk("missing_rvalid", 1'b0, 1'b1);
                    void'(q.pop_front());
                end
            end
            if (vga_gnt) begin
                e.isGame = 1'b0; e.data = expRow(int'(vga_addr)); e.wall = 1'b0; e.cyc = cyc;
                q.push_back(e);
            end else if (game_gnt) begin
                e.isGame = 1'b1; e.data = '0; e.wall = expWall(int'(game_row), int'(game_col)); e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int got;
        bit vg, gg;
        Reset = 1'b1;
        vga_req = 0; vga_addr = 0; game_req = 0; game_row = 0; game_col = 0;
        step(); step();
        Reset = 1'b0;

        // VGA only, rows 0..20 back to back
        for (int r = 0; r < 21; r++) begin
            vga_req = 1; vga_addr = 5'(r);
            @(negedge Clk);
            chk("vga_b2b_gnt", vga_gnt, 1'b1);
            step();
        end
        vga_req = 0;
        repeat (4) step();

        // Simultaneous: VGA first, game next cycle
        vga_req = 1; vga_addr = 5'd3; game_req = 1; game_row = 5'd5; game_col = 5'd0;
        @(negedge Clk);
        chk("sim_vga_gnt", vga_gnt, 1'b1);
        chk("sim_game_wait", game_gnt, 1'b0);
        step();
        vga_req = 0;
        @(negedge Clk);
        chk("sim_game_gnt", game_gnt, 1'b1);
        step();
        game_req = 0;
        repeat (4) step();

        // Boundaries: row 21 must not move rom_addr; col 30 is a wall
        vga_req = 1; vga_addr = 5'd7;
        step();
        vga_req = 0; game_req = 1; game_row = 5'd21; game_col = 5'd4;
        @(negedge Clk);
        chk("oor_row_gnt", game_gnt, 1'b1);
        step();
        chk("oor_row_rom_addr", rom_addr, 5'd7);
        game_row = 5'd2; game_col = 5'd30;
        step();
        chk("oor_col_rom_addr", rom_addr, 5'd2);
        game_req = 0;
        repeat (4) step();

        // Starvation with VGA requesting continuously
        vga_req = 1; vga_addr = 0; game_req = 1; game_row = 5'd4; game_col = 5'd3;
        got = 0;
        for (int k = 1; k <= 20 && got == 0; k++) begin
            @(negedge Clk);
            if (game_gnt) got = k;
            step();
            vga_addr = 5'(k % 21);
        end
        game_req = 0;
`ifdef MAP_ARB_STARVE_GUARD_EN
        chk("starve_forced_cycle", got, 9);
`else
        chk("starve_never_granted", got, 0);
`endif
        vga_req = 0;
        repeat (4) step();

        // Reset mid-flight: grant in N, reset in N+1, nothing in N+2
        vga_req = 1; vga_addr = 5'd6;
        @(negedge Clk);
        chk("mid_rst_gnt", vga_gnt, 1'b1);
        step();
        Reset = 1;
        @(negedge Clk);
        step();
        @(negedge Clk);
        chk("mid_rst_no_rvalid", vga_rvalid, 1'b0);
        step();
        Reset = 0; vga_req = 0;
        repeat (2) step();

        // Random interleaving
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            vg = vga_gnt; gg = game_gnt;
            step();
            if (vg || !vga_req) begin
                vga_req = 1'($urandom_range(0, 1));
                vga_addr = 5'($urandom_range(0, 22));
            end
            if (gg || !game_req) begin
                game_req = 1'($urandom_range(0, 1));
                game_row = 5'($urandom_range(0, 22));
                game_col = 5'($urandom_range(0, 31));
            end
        end
        vga_req = 0; game_req = 0;
        repeat (5) step();
        chk("scoreboard_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
